// File: rtl/sb_cfg_pkg.sv
// Shared types and sizing helpers for the switchbox scan-chain loader.
package sb_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    VERIFY = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } sb_cfg_state_t;

  // Host words needed to cover the whole chain.
  function automatic int unsigned cfg_words(input int unsigned chain_len,
                                            input int unsigned word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  // Bits of the final word that are actually shifted into the chain.
  function automatic int unsigned last_bits(input int unsigned chain_len,
                                            input int unsigned word_w);
    return ((chain_len % word_w) == 0) ? word_w : (chain_len % word_w);
  endfunction

endpackage

// File: rtl/sb_cfg_serializer.sv
// Word buffer that turns host words into an MSB-first bit stream with no
// bubble between back-to-back words; trims the unused tail of the last word.
module sb_cfg_serializer
  import sb_cfg_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 256,
  parameter int unsigned WORD_W    = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_clear,
  input  logic              i_accept_en,
  input  logic              i_word_valid,
  input  logic [WORD_W-1:0] i_word_data,
  output logic              o_word_ready,
  output logic              o_shift,
  output logic              o_bit
);

  localparam int unsigned NWORDS = cfg_words(CHAIN_LEN, WORD_W);
  localparam int unsigned LAST   = last_bits(CHAIN_LEN, WORD_W);
  localparam int unsigned RW     = $clog2(WORD_W + 1);
  localparam int unsigned AW     = $clog2(NWORDS + 1);

  logic [WORD_W-1:0] r_buf;
  logic [RW-1:0]     r_rem;
  logic [AW-1:0]     r_words;
  logic              w_take;
  logic              w_last_word;

  // r_rem is the number of still-unshifted useful bits; a refill is allowed
  // in the cycle the final useful bit leaves so the stream stays continuous.
  always_comb begin
    o_shift      = (r_rem != '0);
    o_bit        = r_buf[WORD_W-1];
    o_word_ready = i_accept_en && (r_words < AW'(NWORDS)) && (r_rem <= RW'(1));
    w_take       = o_word_ready && i_word_valid;
    w_last_word  = (r_words == AW'(NWORDS - 1));
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_buf   <= '0;
      r_rem   <= '0;
      r_words <= '0;
    end else if (i_clear) begin
      r_buf   <= '0;
      r_rem   <= '0;
      r_words <= '0;
    end else if (w_take) begin
      r_buf   <= i_word_data;
      r_rem   <= w_last_word ? RW'(LAST) : RW'(WORD_W);
      r_words <= r_words + AW'(1);
    end else if (o_shift) begin
      r_buf   <= r_buf << 1;
      r_rem   <= r_rem - RW'(1);
    end
  end

endmodule

// File: rtl/sb_config_loader.sv
// Scan-chain bitstream loader: serialises host words into the switchbox chain
// and optionally verifies it by recirculating once and comparing ones-counts.
module sb_config_loader
  import sb_cfg_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 256,
  parameter int unsigned WORD_W    = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              verify,
  input  logic              abort,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              cfg_en,
  output logic              cfg_data,
  input  logic              cfg_ret,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned CW = $clog2(CHAIN_LEN + 1);

  sb_cfg_state_t r_state;
  sb_cfg_state_t w_next;

  logic [CW-1:0] r_bit_cnt;
  logic [CW-1:0] r_ones_ld;
  logic [CW-1:0] r_ones_vf;
  logic          r_verify;

  logic          w_start_ok;
  logic          w_accept_en;
  logic          w_ser_clear;
  logic          w_ser_shift;
  logic          w_ser_bit;
  logic          w_last;
  logic [CW-1:0] w_ones_vf_nxt;

  always_comb begin
    w_start_ok    = start && !abort &&
                    ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));
    w_accept_en   = (r_state == LOAD) && !abort;
    w_ser_clear   = w_start_ok || abort;
    w_last        = (r_bit_cnt == CW'(CHAIN_LEN - 1));
    w_ones_vf_nxt = r_ones_vf + CW'(cfg_ret);
  end

  sb_cfg_serializer #(
    .CHAIN_LEN (CHAIN_LEN),
    .WORD_W    (WORD_W)
  ) u_ser (
    .clk          (clk),
    .nrst         (nrst),
    .i_clear      (w_ser_clear),
    .i_accept_en  (w_accept_en),
    .i_word_valid (word_valid),
    .i_word_data  (word_data),
    .o_word_ready (word_ready),
    .o_shift      (w_ser_shift),
    .o_bit        (w_ser_bit)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state and chain-side outputs; abort overrides every transition.
  always_comb begin
    w_next   = r_state;
    cfg_en   = 1'b0;
    cfg_data = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = LOAD;
      end
      LOAD: begin
        busy     = 1'b1;
        cfg_en   = w_ser_shift;
        cfg_data = w_ser_bit;
        if (w_ser_shift && w_last) w_next = r_verify ? VERIFY : DONE;
      end
      VERIFY: begin
        busy     = 1'b1;
        cfg_en   = 1'b1;
        cfg_data = cfg_ret;
        if (w_last) w_next = (w_ones_vf_nxt == r_ones_ld) ? DONE : ERR;
      end
      DONE: begin
        done = 1'b1;
        if (start) w_next = LOAD;
      end
      ERR: begin
        error = 1'b1;
        if (start) w_next = LOAD;
      end
      default: w_next = IDLE;
    endcase
    if (abort) w_next = IDLE;
  end

  // Shift position and ones-counts for the load and verify passes.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_bit_cnt <= '0;
      r_ones_ld <= '0;
      r_ones_vf <= '0;
      r_verify  <= 1'b0;
    end else if (w_start_ok) begin
      r_bit_cnt <= '0;
      r_ones_ld <= '0;
      r_ones_vf <= '0;
      r_verify  <= verify;
    end else if ((r_state == LOAD) && cfg_en) begin
      r_ones_ld <= r_ones_ld + CW'(cfg_data);
      if (w_last) begin
        r_bit_cnt <= '0;
        r_ones_vf <= '0;
      end else begin
        r_bit_cnt <= r_bit_cnt + CW'(1);
      end
    end else if (r_state == VERIFY) begin
      r_ones_vf <= w_ones_vf_nxt;
      r_bit_cnt <= w_last ? '0 : (r_bit_cnt + CW'(1));
    end
  end

endmodule

// File: tb/tb_sb_config_loader.sv
// Bench for sb_config_loader: 16-bit chain (8-bit words) driven from a vector
// table, plus a 12-bit chain and abort / reset corner sequences.
module tb_sb_config_loader;

  logic        clk;
  logic        nrst;
  logic        abort;

  logic        a_start, a_verify, a_wv, a_wr, a_en, a_data, a_ret, a_busy, a_done, a_err;
  logic [7:0]  a_wd;
  logic        b_start, b_verify, b_wv, b_wr, b_en, b_data, b_ret, b_busy, b_done, b_err;
  logic [7:0]  b_wd;

  logic [15:0] chain_a;
  logic [11:0] chain_b;
  logic        flip_a;
  int          cyc;
  int          n_chk;
  int          n_err;

  sb_config_loader #(.CHAIN_LEN(16), .WORD_W(8)) u_dut_a (
    .clk(clk), .nrst(nrst), .start(a_start), .verify(a_verify), .abort(abort),
    .word_valid(a_wv), .word_data(a_wd), .word_ready(a_wr),
    .cfg_en(a_en), .cfg_data(a_data), .cfg_ret(a_ret),
    .busy(a_busy), .done(a_done), .error(a_err)
  );

  sb_config_loader #(.CHAIN_LEN(12), .WORD_W(8)) u_dut_b (
    .clk(clk), .nrst(nrst), .start(b_start), .verify(b_verify), .abort(abort),
    .word_valid(b_wv), .word_data(b_wd), .word_ready(b_wr),
    .cfg_en(b_en), .cfg_data(b_data), .cfg_ret(b_ret),
    .busy(b_busy), .done(b_done), .error(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Chain models; flip_a inverts the bit that is read next during verify.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      chain_a <= '0;
      chain_b <= '0;
    end else begin
      chain_a <= (a_en ? {chain_a[14:0], a_data} : chain_a) ^ {flip_a, 15'b0};
      chain_b <= b_en ? {chain_b[10:0], b_data} : chain_b;
    end
  end
  assign a_ret = chain_a[15];
  assign b_ret = chain_b[11];

  typedef struct {
    logic [7:0]  w0;
    logic [7:0]  w1;
    logic        vfy;
    logic        flip;
    int          stall;
    logic [15:0] chain;
    logic        done;
    logic        err;
    int          en;
    int          lat;
    int          gaps;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_a(input vec_t v, input int id);
    int          en_cnt = 0;
    int          gaps = 0;
    int          wi = 0;
    int          stall_left = v.stall;
    int          hs_cyc = 0;
    bit          fin = 0;
    logic [15:0] seq = '0;
    logic [7:0]  words [2];
    words[0] = v.w0;
    words[1] = v.w1;
    @(negedge clk);
    a_start = 1'b1; a_verify = v.vfy;
    @(negedge clk);
    a_start = 1'b0; a_verify = 1'b0;
    chk($sformatf("v%0d_busy_start", id), 32'(a_busy), 32'd1);
    chk($sformatf("v%0d_done_start", id), 32'(a_done), 32'd0);
    chk($sformatf("v%0d_err_start", id), 32'(a_err), 32'd0);
    for (int k = 0; k < 200; k++) begin
      if (a_done || a_err) begin fin = 1; break; end
      if (a_en) begin
        if (en_cnt < 16) seq = {seq[14:0], a_data};
        en_cnt++;
      end else if (en_cnt > 0 && en_cnt < 16) begin
        gaps++;
      end
      flip_a = v.flip && a_en && (en_cnt == 20);
      a_wv = (wi < 2) && !(wi == 1 && stall_left > 0);
      a_wd = (wi < 2) ? words[wi] : 8'h00;
      #1;
      if (a_wv && a_wr) begin
        if (wi == 0) hs_cyc = cyc + 1;
        wi++;
      end else if (wi == 1 && stall_left > 0 && a_wr) begin
        stall_left--;
      end
      @(negedge clk);
    end
    a_wv = 1'b0; flip_a = 1'b0;
    chk($sformatf("v%0d_finished", id), 32'(fin), 32'd1);
    chk($sformatf("v%0d_done", id), 32'(a_done), 32'(v.done));
    chk($sformatf("v%0d_error", id), 32'(a_err), 32'(v.err));
    chk($sformatf("v%0d_busy_end", id), 32'(a_busy), 32'd0);
    chk($sformatf("v%0d_en_cycles", id), 32'(en_cnt), 32'(v.en));
    chk($sformatf("v%0d_latency", id), 32'(cyc - hs_cyc), 32'(v.lat));
    chk($sformatf("v%0d_gaps", id), 32'(gaps), 32'(v.gaps));
    chk($sformatf("v%0d_bitseq", id), 32'(seq), 32'({v.w0, v.w1}));
    chk($sformatf("v%0d_chain", id), 32'(chain_a), 32'(v.chain));
    repeat (2) @(negedge clk);
    chk($sformatf("v%0d_done_held", id), 32'(a_done), 32'(v.done));
    chk($sformatf("v%0d_err_held", id), 32'(a_err), 32'(v.err));
    chk($sformatf("v%0d_en_idle", id), 32'(a_en), 32'd0);
  endtask

  initial begin
    n_chk = 0; n_err = 0; cyc = 0;
    nrst = 1'b0; abort = 1'b0; flip_a = 1'b0;
    a_start = 1'b0; a_verify = 1'b0; a_wv = 1'b0; a_wd = '0;
    b_start = 1'b0; b_verify = 1'b0; b_wv = 1'b0; b_wd = '0;

    tbl[0] = '{8'hA5, 8'h3C, 1'b0, 1'b0, 0, 16'hA53C, 1'b1, 1'b0, 16, 16, 0};
    tbl[1] = '{8'hA5, 8'h3C, 1'b1, 1'b0, 0, 16'hA53C, 1'b1, 1'b0, 32, 32, 0};
    tbl[2] = '{8'hA5, 8'h3C, 1'b1, 1'b1, 0, 16'hAD3C, 1'b0, 1'b1, 32, 32, 0};
    tbl[3] = '{8'hA5, 8'h3C, 1'b0, 1'b0, 5, 16'hA53C, 1'b1, 1'b0, 16, 21, 5};
    tbl[4] = '{8'h00, 8'hFF, 1'b1, 1'b0, 0, 16'h00FF, 1'b1, 1'b0, 32, 32, 0};
    tbl[5] = '{8'h81, 8'h7E, 1'b0, 1'b0, 2, 16'h817E, 1'b1, 1'b0, 16, 18, 2};

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_error", 32'(a_err), 32'd0);
    chk("rst_cfg_en", 32'(a_en), 32'd0);
    chk("rst_ready", 32'(a_wr), 32'd0);
    nrst = 1'b1;

    for (int i = 0; i < 6; i++) run_a(tbl[i], i);

    // 12-bit chain: second word only half used, no third word accepted.
    begin : seq_partial
      int en_cnt;
      int hs;
      bit ready_chk;
      logic [7:0] bw [3];
      en_cnt = 0; hs = 0; ready_chk = 0;
      bw[0] = 8'hFF; bw[1] = 8'h9F; bw[2] = 8'h55;
      @(negedge clk);
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      for (int k = 0; k < 60; k++) begin
        if (b_done) break;
        if (b_en) en_cnt++;
        b_wv = 1'b1;
        b_wd = bw[(hs < 2) ? hs : 2];
        #1;
        if (hs == 2 && !ready_chk) begin
          chk("p_ready_after_last", 32'(b_wr), 32'd0);
          ready_chk = 1;
        end
        if (b_wv && b_wr) hs++;
        @(negedge clk);
      end
      b_wv = 1'b0;
      chk("p_done", 32'(b_done), 32'd1);
      chk("p_en_cycles", 32'(en_cnt), 32'd12);
      chk("p_handshakes", 32'(hs), 32'd2);
      chk("p_chain", 32'(chain_b), 32'h0FF9);
      chk("p_ready_checked", 32'(ready_chk), 32'd1);
    end

    // Abort in the cycle the last bit of word 0 shifts (would otherwise be ready).
    begin : seq_abort
      int en_cnt;
      int wi;
      bit hit;
      en_cnt = 0; wi = 0; hit = 0;
      @(negedge clk);
      a_start = 1'b1; a_verify = 1'b0;
      @(negedge clk);
      a_start = 1'b0;
      for (int k = 0; k < 60; k++) begin
        if (a_en) en_cnt++;
        a_wv = 1'b1;
        a_wd = (wi == 0) ? 8'hA5 : 8'h3C;
        if (en_cnt == 8) begin
          abort = 1'b1;
          #1;
          chk("ab_ready_blocked", 32'(a_wr), 32'd0);
          hit = 1;
          break;
        end
        #1;
        if (a_wv && a_wr) wi++;
        @(negedge clk);
      end
      chk("ab_reached", 32'(hit), 32'd1);
      @(negedge clk);
      abort = 1'b0; a_wv = 1'b0;
      #1;
      chk("ab_cfg_en", 32'(a_en), 32'd0);
      chk("ab_busy", 32'(a_busy), 32'd0);
      chk("ab_done", 32'(a_done), 32'd0);
      chk("ab_ready_idle", 32'(a_wr), 32'd0);
      @(negedge clk);
      chk("ab_cfg_en_hold", 32'(a_en), 32'd0);
    end
    run_a(tbl[0], 6);

    // Reset mid-verify, with an ignored start pulse during the load.
    begin : seq_reset
      int en_cnt;
      int wi;
      bit hit;
      en_cnt = 0; wi = 0; hit = 0;
      @(negedge clk);
      a_start = 1'b1; a_verify = 1'b1;
      @(negedge clk);
      a_start = 1'b0; a_verify = 1'b0;
      for (int k = 0; k < 100; k++) begin
        if (a_en) en_cnt++;
        a_start = a_en && (en_cnt == 5);
        if (en_cnt == 17) begin
          chk("rs_vf_ready", 32'(a_wr), 32'd0);
          chk("rs_vf_busy", 32'(a_busy), 32'd1);
        end
        if (en_cnt == 20) begin
          nrst = 1'b0;
          #1;
          chk("rs_busy", 32'(a_busy), 32'd0);
          chk("rs_cfg_en", 32'(a_en), 32'd0);
          chk("rs_done", 32'(a_done), 32'd0);
          chk("rs_error", 32'(a_err), 32'd0);
          hit = 1;
          break;
        end
        a_wv = (wi < 2);
        a_wd = (wi == 0) ? 8'hA5 : 8'h3C;
        #1;
        if (a_wv && a_wr) wi++;
        @(negedge clk);
      end
      a_start = 1'b0; a_wv = 1'b0;
      chk("rs_reached_verify", 32'(hit), 32'd1);
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      chk("rs_idle_busy", 32'(a_busy), 32'd0);
      chk("rs_idle_ready", 32'(a_wr), 32'd0);
      chk("rs_chain_cleared", 32'(chain_a), 32'd0);
    end
    run_a(tbl[1], 7);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
